// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: window offsets,
// address-decode result and the bus-slave state encoding.
package clint_pkg;

  localparam int unsigned N_HARTS_MAX = 16;

  // Offsets relative to BASE_ADDR inside the 64 KiB window
  localparam logic [15:0] REGION_MASK  = 16'hC000;
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIMEH_OFF   = 16'hBFFC;

  typedef enum logic [2:0] {
    DEC_MSIP    = 3'd0,
    DEC_CMP_LO  = 3'd1,
    DEC_CMP_HI  = 3'd2,
    DEC_TIME_LO = 3'd3,
    DEC_TIME_HI = 3'd4,
    DEC_ERR     = 3'd5
  } dec_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_st_e;

  // Byte-lane merge: lanes with strb set take new data, others keep old
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_hart_slice.sv
// One hart's software-interrupt bit, 64-bit timer compare and timer
// interrupt flag.
module clint_hart_slice
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        msip_we_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic [63:0] mtime_i,
  output logic        msip_o,
  output logic [63:0] mtimecmp_o,
  output logic        mtip_o
);

  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic        mtip_q, mtip_d;

  // Next-state: bus writes into msip/mtimecmp, timer compare on current state
  always_comb begin
    msip_d = msip_q;
    cmp_d  = cmp_q;
    if (msip_we_i && wstrb_i[0]) begin
      msip_d = wdata_i[0];
    end else begin
      msip_d = msip_q;
    end
    if (cmp_lo_we_i) begin
      cmp_d[31:0] = merge_bytes(cmp_q[31:0], wdata_i, wstrb_i);
    end else begin
      cmp_d[31:0] = cmp_q[31:0];
    end
    if (cmp_hi_we_i) begin
      cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata_i, wstrb_i);
    end else begin
      cmp_d[63:32] = cmp_q[63:32];
    end
    mtip_d = (mtime_i >= cmp_q);
  end

  // State registers; compare resets to all-ones so no timer interrupt fires
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
      cmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
      cmp_q  <= cmp_d;
      mtip_q <= mtip_d;
    end
  end

  assign msip_o     = msip_q;
  assign mtimecmp_o = cmp_q;
  assign mtip_o     = mtip_q;

endmodule

// File: rtl/clint_multi.sv
// Core-local interruptor: shared prescaled 64-bit mtime, per-hart
// msip/mtimecmp/mtip, behind a one-outstanding valid/ready MMIO slave.
module clint_multi
  import clint_pkg::*;
#(
  parameter int unsigned N_HARTS   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter bit          STRB_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [N_HARTS-1:0] msip,
  output logic [N_HARTS-1:0] mtip,
  output logic [63:0]        mtime_o
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  bus_st_e     st_q, st_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        acc_s, wr_acc_s, tick_s;
  logic [15:0] off_s;
  logic [11:0] msip_idx_s;
  logic [10:0] cmp_idx_s;
  logic [3:0]  strb_s;
  dec_e        dec_s;
  logic [31:0] rdata_s;
  logic        msip_rd_s;
  logic [63:0] cmp_rd_s;
  logic [N_HARTS-1:0] msip_hit_s, cmp_hit_s;
  logic [63:0] cmp_s [N_HARTS];

  assign acc_s      = req_valid && req_ready;
  assign wr_acc_s   = acc_s && req_we;
  assign off_s      = req_addr[15:0];
  assign msip_idx_s = off_s[13:2];
  assign cmp_idx_s  = off_s[13:3];
  assign strb_s     = STRB_EN ? req_wstrb : 4'hF;
  assign tick_s     = (presc_q == TICK_LAST);

  // Address decode: window, alignment, register map and hart range
  always_comb begin
    dec_s = DEC_ERR;
    if ((req_addr[31:16] != BASE_ADDR[31:16]) || (req_addr[1:0] != 2'b00)) begin
      dec_s = DEC_ERR;
    end else if ((off_s & REGION_MASK) == MSIP_OFF) begin
      dec_s = (32'(msip_idx_s) < N_HARTS) ? DEC_MSIP : DEC_ERR;
    end else if ((off_s & REGION_MASK) == MTIMECMP_OFF) begin
      if (32'(cmp_idx_s) < N_HARTS) begin
        dec_s = off_s[2] ? DEC_CMP_HI : DEC_CMP_LO;
      end else begin
        dec_s = DEC_ERR;
      end
    end else if (off_s == MTIME_OFF) begin
      dec_s = DEC_TIME_LO;
    end else if (off_s == MTIMEH_OFF) begin
      dec_s = DEC_TIME_HI;
    end else begin
      dec_s = DEC_ERR;
    end
  end

  for (genvar g = 0; g < N_HARTS; g++) begin : g_hart
    assign msip_hit_s[g] = (dec_s == DEC_MSIP) && (msip_idx_s == 12'(g));
    assign cmp_hit_s[g]  = ((dec_s == DEC_CMP_LO) || (dec_s == DEC_CMP_HI)) &&
                           (cmp_idx_s == 11'(g));
    clint_hart_slice u_slice (
      .clk         (clk),
      .rst         (rst),
      .msip_we_i   (wr_acc_s && msip_hit_s[g]),
      .cmp_lo_we_i (wr_acc_s && cmp_hit_s[g] && (dec_s == DEC_CMP_LO)),
      .cmp_hi_we_i (wr_acc_s && cmp_hit_s[g] && (dec_s == DEC_CMP_HI)),
      .wdata_i     (req_wdata),
      .wstrb_i     (strb_s),
      .mtime_i     (mtime_q),
      .msip_o      (msip[g]),
      .mtimecmp_o  (cmp_s[g]),
      .mtip_o      (mtip[g])
    );
  end

  // Per-hart read select, OR-reduced across harts
  always_comb begin
    msip_rd_s = 1'b0;
    cmp_rd_s  = 64'd0;
    for (int h = 0; h < N_HARTS; h++) begin
      msip_rd_s = msip_rd_s | (msip_hit_s[h] & msip[h]);
      cmp_rd_s  = cmp_rd_s | ({64{cmp_hit_s[h]}} & cmp_s[h]);
    end
  end

  // Read data mux for the decoded register
  always_comb begin
    rdata_s = 32'd0;
    case (dec_s)
      DEC_MSIP:    rdata_s = {31'd0, msip_rd_s};
      DEC_CMP_LO:  rdata_s = cmp_rd_s[31:0];
      DEC_CMP_HI:  rdata_s = cmp_rd_s[63:32];
      DEC_TIME_LO: rdata_s = mtime_q[31:0];
      DEC_TIME_HI: rdata_s = mtime_q[63:32];
      default:     rdata_s = 32'd0;
    endcase
  end

  // mtime/prescaler next state: a bus write beats the tick and restarts the prescaler
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (wr_acc_s && ((dec_s == DEC_TIME_LO) || (dec_s == DEC_TIME_HI))) begin
      presc_d = 16'd0;
      if (dec_s == DEC_TIME_LO) begin
        mtime_d[31:0] = merge_bytes(mtime_q[31:0], req_wdata, strb_s);
      end else begin
        mtime_d[63:32] = merge_bytes(mtime_q[63:32], req_wdata, strb_s);
      end
    end else if (tick_s) begin
      presc_d = 16'd0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      mtime_d = mtime_q;
    end
  end

  // Response payload: read data only for good reads, error flag for bad decodes
  always_comb begin
    resp_rdata_d = (acc_s && !req_we && (dec_s != DEC_ERR)) ? rdata_s : 32'd0;
    resp_err_d   = acc_s && (dec_s == DEC_ERR);
  end

  // Bus slave state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Bus slave next state: one response cycle after every accept
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: st_d = acc_s ? ST_RESP : ST_IDLE;
      ST_RESP: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Bus slave outputs decoded from the state register
  always_comb begin
    req_ready  = (st_q == ST_IDLE);
    resp_valid = (st_q == ST_RESP);
  end

  // Timer and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q      <= 64'd0;
      presc_q      <= 16'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mtime_o    = mtime_q;

endmodule

// File: tb/tb_clint_multi.sv
// Scoreboard bench for clint_multi: two instances (TICK_DIV=1 and 4,
// both with two harts) driven by directed transactions.
module tb_clint_multi;

  localparam logic [31:0] BASE = 32'h0200_0000;

  typedef struct packed {
    logic [95:0] tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk, rst;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_wstrb;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [1:0]  a_msip, a_mtip;
  logic [63:0] a_mtime;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [1:0]  b_msip, b_mtip;
  logic [63:0] b_mtime;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   pulses;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  clint_multi #(.N_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(1), .STRB_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .msip(a_msip), .mtip(a_mtip), .mtime_o(a_mtime)
  );

  clint_multi #(.N_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(4), .STRB_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .msip(b_msip), .mtip(b_mtip), .mtime_o(b_mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench cycle count: clock edges seen with reset released
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one transaction on instance sel (0=a, 1=b) and queue its expected response
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] er, input logic ee, input logic [95:0] tag);
    exp_t e;
    e.tag = tag; e.rdata = er; e.err = ee;
    if (sel == 0) begin
      q_a.push_back(e);
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = ws;
    end else begin
      q_b.push_back(e);
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = ws;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int sel, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] ws, input logic ee, input logic [95:0] tag);
    txn(sel, 1'b1, addr, wd, ws, 32'd0, ee, tag);
  endtask

  task automatic rd(input int sel, input logic [31:0] addr, input logic [31:0] er,
                    input logic ee, input logic [95:0] tag);
    txn(sel, 1'b0, addr, 32'd0, 4'h0, er, ee, tag);
  endtask

  // Response monitor for instance a
  always @(negedge clk) begin
    if (a_resp_valid) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected_resp: got rdata %h err %b, want no response", a_resp_rdata, a_resp_err);
      end else begin
        ea = q_a.pop_front();
        if ({a_resp_rdata, a_resp_err} !== {ea.rdata, ea.err}) begin
          n_bad++;
          $display("FAIL a_%s: got rdata %h err %b, want rdata %h err %b",
                   ea.tag, a_resp_rdata, a_resp_err, ea.rdata, ea.err);
        end
      end
    end
  end

  // Response monitor for instance b
  always @(negedge clk) begin
    if (b_resp_valid) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected_resp: got rdata %h err %b, want no response", b_resp_rdata, b_resp_err);
      end else begin
        eb = q_b.pop_front();
        if ({b_resp_rdata, b_resp_err} !== {eb.rdata, eb.err}) begin
          n_bad++;
          $display("FAIL b_%s: got rdata %h err %b, want rdata %h err %b",
                   eb.tag, b_resp_rdata, b_resp_err, eb.rdata, eb.err);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0; a_req_wstrb = 4'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_req_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_a_ready", a_req_ready, 64'd1);
    check("rst_a_resp_valid", a_resp_valid, 64'd0);
    check("rst_a_msip", a_msip, 64'd0);
    check("rst_a_mtip", a_mtip, 64'd0);
    check("rst_a_mtime", a_mtime, 64'd0);
    check("rst_b_mtime", b_mtime, 64'd0);
    check("rst_b_mtip", b_mtip, 64'd0);

    // Instance b: MTIMECMP[1] = 5, hi half first
    wr(1, BASE + 32'h400C, 32'd0, 4'hF, 1'b0, "wr_cmp1_hi");
    wr(1, BASE + 32'h4008, 32'd5, 4'hF, 1'b0, "wr_cmp1_lo");
    rd(1, BASE + 32'h400C, 32'd0, 1'b0, "rd_cmp1_hi");
    rd(1, BASE + 32'h4008, 32'd5, 1'b0, "rd_cmp1_lo");

    // Instance a: mtime counts every cycle since reset release
    @(posedge clk); #1;
    rd(0, BASE + 32'hBFF8, 32'(cyc), 1'b0, "rd_mtime_lo");
    rd(0, BASE + 32'h4004, 32'hFFFF_FFFF, 1'b0, "rd_cmp0_hi");
    check("a_mtip_idle", a_mtip, 64'd0);

    // Instance b: mtime reaches 5 after 20 cycles, mtip[1] one cycle later
    while (cyc < 19) begin
      @(posedge clk); #1;
    end
    check("b_mtime_c19", b_mtime, 64'd4);
    check("b_mtip_c19", b_mtip, 64'd0);
    @(posedge clk); #1;
    check("b_mtime_c20", b_mtime, 64'd5);
    check("b_mtip_c20", b_mtip, 64'd0);
    @(posedge clk); #1;
    check("b_mtip_c21", b_mtip, 64'h2);

    // Instance b: an MTIME write restarts the prescaler (accept off a natural tick)
    if (((cyc + 1) % 4) == 0) begin
      @(posedge clk); #1;
    end
    wr(1, BASE + 32'hBFF8, 32'h100, 4'hF, 1'b0, "wr_mtime_lo");
    check("b_presc_w1", b_mtime, 64'h100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b_presc_w3", b_mtime, 64'h100);
    @(posedge clk); #1;
    check("b_presc_w4", b_mtime, 64'h101);

    // Instance a: 32-bit carry, then hi write on a tick cycle holds lo
    wr(0, BASE + 32'hBFFC, 32'd0, 4'hF, 1'b0, "wr_mtime_hi");
    wr(0, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_mtime_lo");
    check("a_carry", a_mtime, 64'h0000_0001_0000_0000);
    rd(0, BASE + 32'hBFFC, 32'd1, 1'b0, "rd_carry_hi");
    rd(0, BASE + 32'hBFF8, 32'd2, 1'b0, "rd_carry_lo");
    wr(0, BASE + 32'hBFFC, 32'h55, 4'hF, 1'b0, "wr_hi_tick");
    check("a_hi_on_tick", a_mtime, 64'h0000_0055_0000_0005);

    // Instance a: MSIP[1] set/readback/clear
    wr(0, BASE + 32'h0004, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_msip1");
    check("a_msip_set", a_msip, 64'h2);
    rd(0, BASE + 32'h0004, 32'd1, 1'b0, "rd_msip1");
    rd(0, BASE + 32'h0000, 32'd0, 1'b0, "rd_msip0");
    wr(0, BASE + 32'h0004, 32'd0, 4'hF, 1'b0, "clr_msip1");
    check("a_msip_clr", a_msip, 64'd0);
    wr(0, BASE + 32'h0004, 32'd1, 4'hF, 1'b0, "set_msip1");
    check("a_msip_reset", a_msip, 64'h2);

    // Error cases, none of which may change msip
    rd(0, BASE + 32'h4010, 32'd0, 1'b1, "rd_cmp_h2");
    wr(0, BASE + 32'h0006, 32'd0, 4'hF, 1'b1, "wr_misalign");
    check("a_msip_misalign", a_msip, 64'h2);
    wr(0, BASE + 32'h0001_0004, 32'd0, 4'hF, 1'b1, "wr_outwin");
    check("a_msip_outwin", a_msip, 64'h2);
    rd(0, BASE + 32'h0008, 32'd0, 1'b1, "rd_msip_h2");
    rd(0, BASE + 32'h8000, 32'd0, 1'b1, "rd_reserved");

    // Byte-lane write onto the reset value of MTIMECMP[0] lo
    wr(0, BASE + 32'h4000, 32'hAABB_CCDD, 4'b0010, 1'b0, "wr_strb");
    rd(0, BASE + 32'h4000, 32'hFFFF_CCFF, 1'b0, "rd_strb");

    // req_valid held high: one accept every second cycle
    for (int k = 0; k < 4; k++) begin
      q_a.push_back('{tag: "rd_b2b", rdata: 32'hFFFF_CCFF, err: 1'b0});
    end
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = BASE + 32'h4000; a_req_wstrb = 4'h0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_resp_valid) pulses++;
      check("b2b_ready", a_req_ready, ((i % 2) == 1) ? 64'd1 : 64'd0);
      if (i == 6) a_req_valid = 1'b0;
    end
    check("b2b_pulses", 64'(pulses), 64'd4);

    // Reset during an accept cycle drops the request
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = BASE; a_req_wdata = 32'd1; a_req_wstrb = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst = 1'b0;
    check("rst2_resp_valid", a_resp_valid, 64'd0);
    check("rst2_ready", a_req_ready, 64'd1);
    check("rst2_msip", a_msip, 64'd0);
    check("rst2_a_mtime", a_mtime, 64'd0);
    check("rst2_b_mtime", b_mtime, 64'd0);
    check("rst2_b_mtip", b_mtip, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("q_a_left", 64'(q_a.size()), 64'd0);
    check("q_b_left", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_multi.md
Name: clint_multi

Overview:
Parametrised core-local interruptor, the successor to the fixed single-hart timer/MSIP logic embedded in the unified memory block. It provides a 64-bit mtime with a programmable tick prescaler, and a per-hart mtimecmp and msip for N_HARTS harts. It sits on the data-memory side as an MMIO slave with a registered valid/ready request/response handshake, and drives msip/mtip into each hart's CSR unit.

Parameters:
N_HARTS, 1, number of harts (1..16); one msip/mtimecmp/mtip set per hart
BASE_ADDR, 32'h0200_0000, MMIO base of the CLINT window (64 KiB aligned)
TICK_DIV, 1, clk cycles per mtime increment (1..65535); 1 = every cycle
STRB_EN, 1, 1 = honour req_wstrb byte enables; 0 = full-word writes only

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  slave can accept request
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte enables for writes
resp_valid  out  1  response valid (one cycle)
resp_rdata  out  32  read data (0 on writes/errors)
resp_err  out  1  access outside the decoded map or misaligned
msip  out  N_HARTS  software interrupt pending, per hart
mtip  out  N_HARTS  timer interrupt pending, per hart (registered)
mtime_o  out  64  current mtime, for time/timeh CSR reads

Behaviour:
- Map (offset from BASE_ADDR): MSIP[h] at 0x0000+4h (bit 0 only, others read 0); MTIMECMP[h] lo at 0x4000+8h, hi at 0x4004+8h; MTIME lo at 0xBFF8, hi at 0xBFFC.
- Any other offset inside the window, h >= N_HARTS, addr outside the window, or req_addr[1:0] != 0 -> resp_err=1, no state change, rdata=0.
- Handshake: request accepted when req_valid && req_ready. resp_valid is asserted exactly the cycle after acceptance. req_ready = !resp_valid || (no pending resp). At most one transaction is outstanding, so there are no back-to-back accepts: throughput is 1 per 2 cycles.
- Reads sample the register value in the accept cycle.
- Writes: byte-lane merge with req_wstrb when STRB_EN=1. When STRB_EN=0, wstrb is ignored and the full word is written.
- Prescaler: 16-bit counter. Counts 0..TICK_DIV-1; on wrap, mtime <= mtime+1 (full 64-bit carry, wraps 2^64-1 -> 0).
- Simultaneous bus write to an MTIME half and a tick: the write wins for the written half; the other half holds, with no increment that cycle. A write to MTIME also clears the prescaler to 0.
- mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit, registered. It reflects register state with a 1-cycle lag.
- A write to mtimecmp lo and a write to mtimecmp hi are separate transactions, so software uses the standard hi=all-ones sequence. No atomic 64-bit write.
- msip[h] is driven directly from a register bit. Writing 1 sets it, writing 0 clears it.
- mtime_o is the live register value.
- Reset values (rst takes priority over any bus activity, including mid-transaction):
  - mtime=0, prescaler=0
  - mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, so mtip=0
  - msip=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1
  - A request in flight at reset is dropped with no response.
- No FSM beyond the 2-state bus slave: IDLE (ready=1) -> RESP on accept; RESP -> IDLE unconditionally.

Decomposition:
- Shared package clint_pkg: BASE-relative offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), N_HARTS_MAX=16, and the address-decode result enum (DEC_MSIP, DEC_CMP_LO, DEC_CMP_HI, DEC_TIME_LO, DEC_TIME_HI, DEC_ERR).
- The address-decode enum also goes into csr_defs, replacing the fixed CLINT_* address defines.
- One sub-module, clint_hart_slice, instantiated N_HARTS times. Each holds one hart's msip bit, 64-bit mtimecmp with byte-merge writes, and the registered mtip compare.

Test Plan:
- Reset, then read MTIME lo at cycle 10 with TICK_DIV=1 -> rdata = number of cycles since reset deassert (±1, value checked against model). Read MTIMECMP[0] hi -> 32'hFFFF_FFFF; mtip=0.
- TICK_DIV=4, N_HARTS=2: write MTIMECMP[1] = 64'd5 (hi then lo) -> mtip[1] rises exactly 1 cycle after mtime reaches 5 (after 20 clk); mtip[0] stays 0.
- Write MTIME = 64'h0000_0000_FFFF_FFFF, TICK_DIV=1 -> after 1 tick, hi=1, lo=0 (carry). Then write MTIME hi on a tick cycle -> the written value is held with no increment that cycle, and the prescaler is cleared.
- Write MSIP[1]=32'hFFFF_FFFF -> msip=2'b10 next cycle, and readback = 32'h1. Write 0 -> msip[1] clears.
- Error cases, each with no state change:
  - Read BASE+0x4010 with N_HARTS=2 -> resp_err=1, rdata=0.
  - Write to BASE+0x0002 (misaligned) -> resp_err=1, msip unchanged.
- With STRB_EN=1, write MTIMECMP[0] lo with wstrb=4'b0010, wdata=32'hAABBCCDD onto reset value -> reads 32'hFFFF_CCFF. Then hold req_valid high continuously -> accepts only every 2nd cycle, and resp_valid pulses once per accept.
